// File: rtl/attempt_lockout_if.sv
//------------------------------------------------------------------------------
// Module      : attempt_lockout_if
// Description : Key/comparator side and indicator side signals of the
//               safebox attempt-lockout controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface attempt_lockout_if;
  logic       try_open;
  logic       pw_match;
  logic       close_req;
  logic       opened;
  logic       locked;
  logic       alarm;
  logic [1:0] fail_cnt;
  logic       clean_entry;

  // Driver of key pulses / comparator result (keypad side).
  modport master (
    output try_open, pw_match, close_req,
    input  opened, locked, alarm, fail_cnt, clean_entry
  );

  // The controller itself.
  modport slave (
    input  try_open, pw_match, close_req,
    output opened, locked, alarm, fail_cnt, clean_entry
  );
endinterface

`default_nettype wire

// File: rtl/attempt_lockout_ctrl.sv
//------------------------------------------------------------------------------
// Module      : attempt_lockout_ctrl
// Description : Judges open requests against the password match flag, counts
//               consecutive failures, drives a timed alarm and enforces a
//               timed lockout after MAX_FAILS failures.
//               Optional macro LOCKOUT_ESCALATE_EN: each lockout doubles the
//               previous duration (up to x8) until the next successful open.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module attempt_lockout_ctrl #(
  parameter int TICK_CYCLES = 50000,
  parameter int MAX_FAILS   = 3,
  parameter int ALARM_TICKS = 3000,
  parameter int LOCK_TICKS  = 10000
) (
  input  logic               clk,
  input  logic               rst,
  attempt_lockout_if.slave   bus
);

  // Timer widths cover the longest escalated lockout as well as the alarm.
  localparam int LOCK_MAX = LOCK_TICKS << 3;
  localparam int TW       = $clog2(((LOCK_MAX > ALARM_TICKS) ? LOCK_MAX : ALARM_TICKS) + 1);
  localparam int PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] ALARM_LOAD = TW'(ALARM_TICKS);
  localparam logic [TW-1:0] LOCK_BASE  = TW'(LOCK_TICKS);
  localparam logic [TW-1:0] CNT_ONE    = TW'(1);
  localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAILS);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t        state;
  logic          opened;
  logic          locked;
  logic          alarm;
  logic [1:0]    fail_cnt;
  logic          clean_entry;

  logic [TW-1:0] alarm_cnt;
  logic [PW-1:0] alarm_presc;
  logic [TW-1:0] lock_cnt;
  logic [PW-1:0] lock_presc;
  logic [TW-1:0] lock_ticks;

  logic          try_good;
  logic          try_bad;
  logic          lock_enter;
  logic          alarm_tick;
  logic          lock_tick;
  logic          lock_expire;

  // Attempts are only judged while closed; lockout and open ignore pw_match.
  assign try_good    = (state == CLOSED) &&  bus.try_open &&  bus.pw_match;
  assign try_bad     = (state == CLOSED) &&  bus.try_open && !bus.pw_match;
  assign lock_enter  = try_bad && ((fail_cnt + 2'd1) == FAIL_LIMIT);
  assign alarm_tick  = (alarm_presc == PRESC_LAST);
  assign lock_tick   = (lock_presc == PRESC_LAST);
  assign lock_expire = (state == LOCKOUT) && (lock_cnt == CNT_ONE) && lock_tick;

`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] lock_level;

  // Escalation level survives lockout exit; only a good open resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_level <= 2'd0;
    end else if (try_good) begin
      lock_level <= 2'd0;
    end else if (lock_enter && (lock_level != 2'd3)) begin
      lock_level <= lock_level + 2'd1;
    end
  end

  assign lock_ticks = LOCK_BASE << lock_level;
`else
  assign lock_ticks = LOCK_BASE;
`endif

  // Attempt sequencer: state, open/locked flags, failure count, entry clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLOSED;
      opened      <= 1'b0;
      locked      <= 1'b0;
      fail_cnt    <= 2'd0;
      clean_entry <= 1'b0;
    end else begin
      clean_entry <= 1'b0;
      case (state)
        CLOSED: begin
          if (bus.try_open) begin
            clean_entry <= 1'b1;
            if (bus.pw_match) begin
              state    <= OPEN;
              opened   <= 1'b1;
              fail_cnt <= 2'd0;
            end else if (lock_enter) begin
              state    <= LOCKOUT;
              locked   <= 1'b1;
              fail_cnt <= FAIL_LIMIT;
            end else begin
              fail_cnt <= fail_cnt + 2'd1;
            end
          end
        end
        OPEN: begin
          // Key toggle and close request collapse into one close event.
          if (bus.try_open || bus.close_req) begin
            state       <= CLOSED;
            opened      <= 1'b0;
            clean_entry <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (lock_expire) begin
            state    <= CLOSED;
            locked   <= 1'b0;
            fail_cnt <= 2'd0;
          end
        end
        default: begin
          state    <= CLOSED;
          opened   <= 1'b0;
          locked   <= 1'b0;
          fail_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Alarm window: reloaded by every failure, cancelled by a good open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm       <= 1'b0;
      alarm_cnt   <= '0;
      alarm_presc <= '0;
    end else if (try_good) begin
      alarm       <= 1'b0;
      alarm_cnt   <= '0;
      alarm_presc <= '0;
    end else if (try_bad) begin
      alarm       <= 1'b1;
      alarm_cnt   <= ALARM_LOAD;
      alarm_presc <= '0;
    end else if (alarm_cnt != '0) begin
      if (alarm_tick) begin
        alarm_presc <= '0;
        alarm_cnt   <= alarm_cnt - CNT_ONE;
        if (alarm_cnt == CNT_ONE) begin
          alarm <= 1'b0;
        end
      end else begin
        alarm_presc <= alarm_presc + 1'b1;
      end
    end
  end

  // Lockout window: loaded on lockout entry, its expiry releases the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt   <= '0;
      lock_presc <= '0;
    end else if (lock_enter) begin
      lock_cnt   <= lock_ticks;
      lock_presc <= '0;
    end else if (lock_cnt != '0) begin
      if (lock_tick) begin
        lock_presc <= '0;
        lock_cnt   <= lock_cnt - CNT_ONE;
      end else begin
        lock_presc <= lock_presc + 1'b1;
      end
    end
  end

  assign bus.opened      = opened;
  assign bus.locked      = locked;
  assign bus.alarm       = alarm;
  assign bus.fail_cnt    = fail_cnt;
  assign bus.clean_entry = clean_entry;

endmodule

`default_nettype wire

// File: tb/tb_attempt_lockout_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_attempt_lockout_ctrl
// Description : Directed self-checking bench for attempt_lockout_ctrl
//               (TICK_CYCLES=4, ALARM_TICKS=2, LOCK_TICKS=5, MAX_FAILS=3).
//               Honors LOCKOUT_ESCALATE_EN for lockout duration expectations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_attempt_lockout_ctrl;

  localparam int LIM = 400;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  attempt_lockout_if bus();

  attempt_lockout_ctrl #(
    .TICK_CYCLES (4),
    .MAX_FAILS   (3),
    .ALARM_TICKS (2),
    .LOCK_TICKS  (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.try_open  = 1'b0;
    bus.pw_match  = 1'b0;
    bus.close_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle pulse; returns at the negedge after the response edge.
  task automatic pulse(input logic t, input logic pw, input logic c);
    @(negedge clk);
    bus.try_open  = t;
    bus.pw_match  = pw;
    bus.close_req = c;
    @(negedge clk);
    bus.try_open  = 1'b0;
    bus.pw_match  = 1'b0;
    bus.close_req = 1'b0;
  endtask

  task automatic measure_alarm(output int n);
    n = 0;
    while (bus.alarm && n < LIM) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic measure_locked(output int n);
    n = 0;
    while (bus.locked && n < LIM) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic lock_now();
    repeat (3) pulse(1'b1, 1'b0, 1'b0);
  endtask

  int n;
  int exp_lock [3];

  initial begin
    checks = 0;
    errors = 0;
`ifdef LOCKOUT_ESCALATE_EN
    exp_lock[0] = 20; exp_lock[1] = 40; exp_lock[2] = 80;
`else
    exp_lock[0] = 20; exp_lock[1] = 20; exp_lock[2] = 20;
`endif

    // 1: reset state, good open, close request
    do_reset();
    check_val("rst_opened", {31'd0, bus.opened}, 0);
    check_val("rst_locked", {31'd0, bus.locked}, 0);
    check_val("rst_alarm", {31'd0, bus.alarm}, 0);
    check_val("rst_fail_cnt", {30'd0, bus.fail_cnt}, 0);
    check_val("rst_clean", {31'd0, bus.clean_entry}, 0);
    pulse(1'b1, 1'b1, 1'b0);
    check_val("open_opened", {31'd0, bus.opened}, 1);
    check_val("open_clean", {31'd0, bus.clean_entry}, 1);
    check_val("open_fail_cnt", {30'd0, bus.fail_cnt}, 0);
    @(negedge clk);
    check_val("open_clean_1cyc", {31'd0, bus.clean_entry}, 0);
    pulse(1'b0, 1'b0, 1'b1);
    check_val("close_opened", {31'd0, bus.opened}, 0);
    check_val("close_clean", {31'd0, bus.clean_entry}, 1);
    @(negedge clk);
    check_val("close_clean_1cyc", {31'd0, bus.clean_entry}, 0);
    pulse(1'b0, 1'b0, 1'b1);
    check_val("closed_close_ign", {31'd0, bus.clean_entry}, 0);

    // 2: one bad try, 8-cycle alarm
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    check_val("bad_fail_cnt", {30'd0, bus.fail_cnt}, 1);
    check_val("bad_clean", {31'd0, bus.clean_entry}, 1);
    check_val("bad_opened", {31'd0, bus.opened}, 0);
    measure_alarm(n);
    check_val("alarm_len", n, 8);
    check_val("bad_opened_after", {31'd0, bus.opened}, 0);

    // 3: lockout 20 cycles, mid-lockout good try ignored
    do_reset();
    lock_now();
    check_val("lk_locked", {31'd0, bus.locked}, 1);
    check_val("lk_fail_cnt", {30'd0, bus.fail_cnt}, 3);
    check_val("lk_alarm", {31'd0, bus.alarm}, 1);
    n = 0;
    while (bus.locked && n < LIM) begin
      if (n == 5) begin
        bus.try_open = 1'b1;
        bus.pw_match = 1'b1;
      end
      if (n == 6) begin
        bus.try_open = 1'b0;
        bus.pw_match = 1'b0;
        check_val("lk_try_opened", {31'd0, bus.opened}, 0);
        check_val("lk_try_clean", {31'd0, bus.clean_entry}, 0);
        check_val("lk_try_cnt", {30'd0, bus.fail_cnt}, 3);
      end
      n++;
      @(negedge clk);
    end
    check_val("lk_len", n, 20);
    check_val("lk_exit_locked", {31'd0, bus.locked}, 0);
    check_val("lk_exit_cnt", {30'd0, bus.fail_cnt}, 0);
    check_val("lk_exit_opened", {31'd0, bus.opened}, 0);

    // 4: two bad then good; toggle close; simultaneous close pulses
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("two_bad_cnt", {30'd0, bus.fail_cnt}, 2);
    check_val("two_bad_alarm", {31'd0, bus.alarm}, 1);
    pulse(1'b1, 1'b1, 1'b0);
    check_val("good_opened", {31'd0, bus.opened}, 1);
    check_val("good_cnt", {30'd0, bus.fail_cnt}, 0);
    check_val("good_alarm", {31'd0, bus.alarm}, 0);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("toggle_opened", {31'd0, bus.opened}, 0);
    check_val("toggle_clean", {31'd0, bus.clean_entry}, 1);
    check_val("toggle_cnt", {30'd0, bus.fail_cnt}, 0);
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check_val("both_opened", {31'd0, bus.opened}, 0);
    check_val("both_clean", {31'd0, bus.clean_entry}, 1);
    @(negedge clk);
    check_val("both_clean_1cyc", {31'd0, bus.clean_entry}, 0);

    // 5: async reset mid-lockout / mid-alarm
    do_reset();
    lock_now();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_locked", {31'd0, bus.locked}, 0);
    check_val("arst_alarm", {31'd0, bus.alarm}, 0);
    check_val("arst_cnt", {30'd0, bus.fail_cnt}, 0);
    check_val("arst_opened", {31'd0, bus.opened}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse(1'b1, 1'b1, 1'b0);
    check_val("arst_reopen", {31'd0, bus.opened}, 1);

    // 6: consecutive lockouts, then good open returns to base duration
    do_reset();
    for (int k = 0; k < 3; k++) begin
      lock_now();
      measure_locked(n);
      check_val($sformatf("esc_len%0d", k), n, exp_lock[k]);
    end
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    lock_now();
    measure_locked(n);
    check_val("esc_after_open", n, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
